// File: rtl/foo_pipe_arb_pkg.sv
// rtl/foo_pipe_arb_pkg.sv - shared types and defaults for the pipelined round-robin arbiter
//
// Purpose: FSM state enum, default parameter values and the in-flight tag
// record used by foo_pipe_arb and foo_rr_pick.
package foo_pipe_arb_pkg;

  localparam int NUM_REQ_DEF  = 4;
  localparam int DATA_W_DEF   = 32;
  localparam int PIPE_LAT_DEF = 3;

  // Wide enough for the largest supported requester count (16).
  localparam int TAG_ID_W = 4;
  localparam int STAT_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/foo_rr_pick.sv
// rtl/foo_rr_pick.sv - combinational round-robin picker
//
// Purpose: find the first asserted request at or after ptr, wrapping modulo
// NUM_REQ.
// Ports:
//   req    in  NUM_REQ  request vector
//   ptr    in  IDX_W    search start index
//   grant  out NUM_REQ  one-hot winner, zero when no request
//   idx    out IDX_W    winner index, zero when no request
module foo_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic             found;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // One spare bit so ptr+k can be folded back below NUM_REQ.
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/foo_pipe_arb.sv
// rtl/foo_pipe_arb.sv - round-robin front end for a shared fixed-latency pipeline
//
// Purpose: grants one requester per cycle into a non-stalling pipeline, tags
// each launch with its requester id and steers the result back to that
// requester PIPE_LAT cycles later.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enable          permits new grants
//   req_valid/data  per-requester request and packed operands
//   req_ready       one-hot grant
//   pipe_in_valid/pipe_x     launch to the pipeline
//   pipe_out_valid/pipe_out  result from the pipeline
//   resp_valid/resp_data     one-hot result strobe and result
//   idle            registered (state == IDLE)
//   tag_err         sticky pipeline/tag valid mismatch
//   grant_cnt       per-requester saturating transfer counters
//                   (only with FOO_PIPE_ARB_STATS_EN defined)
module foo_pipe_arb
  import foo_pipe_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  pipe_in_valid,
  output logic [DATA_W-1:0]     pipe_x,
  input  logic                  pipe_out_valid,
  input  logic [DATA_W-1:0]     pipe_out,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [DATA_W-1:0]     resp_data,
  output logic                  idle,
  output logic                  tag_err
`ifdef FOO_PIPE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] grant_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(PIPE_LAT+1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  tag_t               tags [PIPE_LAT];
  tag_t               tag_last;
  logic [CNT_W-1:0]   inflight, inflight_nxt;
  logic               tag_err_q;
  logic               grant_en;
  logic               tag_ok;
  logic               tag_mismatch;

  foo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Outputs are forced quiet in the reset cycle itself, not only afterwards.
  assign grant_en      = (state == RUN) && enable && !rst;
  assign req_ready     = grant_en ? pick_grant : '0;
  assign pipe_in_valid = |(req_ready & req_valid);

  always_comb begin
    pipe_x = '0;
    if (pipe_in_valid) begin
      pipe_x = req_data[int'(pick_idx)*DATA_W +: DATA_W];
    end
  end

  assign tag_last     = tags[PIPE_LAT-1];
  assign tag_mismatch = (pipe_out_valid != tag_last.valid);
  assign tag_ok       = pipe_out_valid && tag_last.valid && !rst;

  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = tag_ok && (tag_last.id == TAG_ID_W'(i));
    end
    if (tag_ok) begin
      resp_data = pipe_out;
    end
  end

  assign tag_err = tag_err_q && !rst;

  always_comb begin
    inflight_nxt = inflight;
    if (pipe_in_valid && !pipe_out_valid && inflight != CNT_W'(PIPE_LAT)) begin
      inflight_nxt = inflight + 1'b1;
    end else if (!pipe_in_valid && pipe_out_valid && inflight != '0) begin
      inflight_nxt = inflight - 1'b1;
    end
  end

  // Exit decisions look at the count after this cycle's retire, so idle
  // rises the cycle after the last response.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = (inflight_nxt == '0) ? IDLE : DRAIN;
      DRAIN: begin
        if (enable)                   state_nxt = RUN;
        else if (inflight_nxt == '0)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idle      <= 1'b1;
      rr_ptr    <= '0;
      inflight  <= '0;
      tag_err_q <= 1'b0;
      for (int k = 0; k < PIPE_LAT; k++) begin
        tags[k] <= '0;
      end
    end else begin
      state    <= state_nxt;
      idle     <= (state_nxt == IDLE);
      inflight <= inflight_nxt;
      if (tag_mismatch) begin
        tag_err_q <= 1'b1;
      end
      if (pipe_in_valid) begin
        rr_ptr <= (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
      end
      tags[0] <= '{valid: pipe_in_valid, id: TAG_ID_W'(pick_idx)};
      for (int k = 1; k < PIPE_LAT; k++) begin
        tags[k] <= tags[k-1];
      end
    end
  end

`ifdef FOO_PIPE_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && req_valid[i] && cnt_q[i] != {STAT_W{1'b1}}) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*STAT_W +: STAT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_foo_pipe_arb.sv
// tb/tb_foo_pipe_arb.sv - randomized self-checking bench for foo_pipe_arb
module tb_foo_pipe_arb;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic            clk;
  logic            rst;
  logic            enable;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            pipe_in_valid;
  logic [DW-1:0]   pipe_x;
  logic            pipe_out_valid;
  logic [DW-1:0]   pipe_out;
  logic [NR-1:0]   resp_valid;
  logic [DW-1:0]   resp_data;
  logic            idle;
  logic            tag_err;
  logic            inject;
`ifdef FOO_PIPE_ARB_STATS_EN
  logic [NR*16-1:0] grant_cnt;
`endif

  foo_pipe_arb #(.NUM_REQ(NR), .DATA_W(DW), .PIPE_LAT(LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .pipe_in_valid  (pipe_in_valid),
    .pipe_x         (pipe_x),
    .pipe_out_valid (pipe_out_valid),
    .pipe_out       (pipe_out),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .idle           (idle),
    .tag_err        (tag_err)
`ifdef FOO_PIPE_ARB_STATS_EN
    ,
    .grant_cnt      (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stitched pipeline: x+1, then +1 on the upper 31 bits, then a plain stage.
  logic          s1_v, s2_v, s3_v;
  logic [DW-1:0] s1_d, s2_d, s3_d;
  always @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s3_v <= 1'b0;
      s1_d <= '0;   s2_d <= '0;   s3_d <= '0;
    end else begin
      s1_v <= pipe_in_valid; s1_d <= pipe_x + 1;
      s2_v <= s1_v;          s2_d <= {s1_d[DW-1:1] + 31'd1, s1_d[0]};
      s3_v <= s2_v;          s3_d <= s2_d;
    end
  end
  assign pipe_out_valid = s3_v | inject;
  assign pipe_out       = s3_d;

  // Reference model: a queue of launched transactions with due cycles.
  typedef struct {
    int          due;
    int          id;
    logic [31:0] val;
  } pend_t;

  pend_t pend [$];
  int    m_state;   // 0 idle, 1 run, 2 drain
  int    m_ptr;
  bit    m_tag_err;
  bit    m_idle;
  int    m_gcnt [NR];
  int    cyc;
  int    n_checks;
  int    n_errors;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input bit en, input logic [NR-1:0] rv,
                      input logic [NR*DW-1:0] d, input bit inj);
    int          gi;
    logic [NR-1:0] e_ready, e_resp;
    logic [31:0] e_x, e_rdata;
    bit          real_out, outv;
    rst = r; enable = en; req_valid = rv; req_data = d; inject = inj;
    #2;
    gi = -1; e_ready = '0; e_resp = '0; e_x = '0; e_rdata = '0;
    real_out = !r && pend.size() > 0 && pend[0].due == cyc;
    outv     = real_out || inj;
    if (!r) begin
      if (m_state == 1 && en) begin
        for (int k = 0; k < NR; k++) begin
          int i;
          i = (m_ptr + k) % NR;
          if (gi < 0 && rv[i]) gi = i;
        end
      end
      if (gi >= 0) begin
        e_ready[gi] = 1'b1;
        e_x = d[gi*DW +: DW];
      end
      if (real_out) begin
        e_resp[pend[0].id] = 1'b1;
        e_rdata = pend[0].val + 32'd3;
      end
    end
    check("req_ready",     req_ready,     e_ready);
    check("pipe_in_valid", pipe_in_valid, gi >= 0);
    check("pipe_x",        pipe_x,        e_x);
    check("resp_valid",    resp_valid,    e_resp);
    check("resp_data",     resp_data,     e_rdata);
    check("tag_err",       tag_err,       r ? 1'b0 : m_tag_err);
    if (!r) check("idle", idle, m_idle);

    if (r) begin
      pend.delete();
      m_state = 0; m_ptr = 0; m_tag_err = 0; m_idle = 1;
      for (int i = 0; i < NR; i++) m_gcnt[i] = 0;
    end else begin
      if (real_out) void'(pend.pop_front());
      else if (outv) m_tag_err = 1;
      if (gi >= 0) begin
        pend.push_back('{cyc + LAT, gi, d[gi*DW +: DW]});
        m_ptr = (gi + 1) % NR;
        m_gcnt[gi]++;
      end
      case (m_state)
        0: if (en) m_state = 1;
        1: if (!en) m_state = (pend.size() == 0) ? 0 : 2;
        default: begin
          if (en) m_state = 1;
          else if (pend.size() == 0) m_state = 0;
        end
      endcase
      m_idle = (m_state == 0);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NR*DW-1:0] rnd_data();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  logic [NR*DW-1:0] d10;

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    m_state = 0; m_ptr = 0; m_tag_err = 0; m_idle = 1;
    for (int i = 0; i < NR; i++) m_gcnt[i] = 0;
    rst = 1'b1; enable = 1'b0; req_valid = '0; req_data = '0; inject = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) step(1, 0, '0, '0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, '0, '0, 0);

    // Single request from requester 2 with operand 10.
    d10 = '0;
    d10[2*DW +: DW] = 32'd10;
    step(0, 1, 4'b0100, d10, 0);
    step(0, 1, 4'b0100, d10, 0);
    for (int i = 0; i < 5; i++) step(0, 1, '0, '0, 0);

    // All four requesting continuously from rr_ptr = 0.
    step(1, 0, '0, '0, 0);
    step(0, 1, '0, '0, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 4'b1111, rnd_data(), 0);
    for (int i = 0; i < 5; i++) step(0, 1, '0, '0, 0);

    // Drain: three back-to-back grants then enable low, requests still up.
    for (int i = 0; i < 3; i++) step(0, 1, 4'b1111, rnd_data(), 0);
    for (int i = 0; i < 8; i++) step(0, 0, 4'b1111, rnd_data(), 0);

    // Reset with two items in flight.
    step(0, 1, '0, '0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 4'b0011, rnd_data(), 0);
    step(1, 1, 4'b0011, rnd_data(), 0);
    for (int i = 0; i < 6; i++) step(0, 0, '0, '0, 0);

    // Spurious pipeline output with an empty tag register.
    step(0, 0, '0, '0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 0);
    for (int i = 0; i < 2; i++) step(1, 0, '0, '0, 0);

    // Randomized traffic with occasional enable drops and resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 250) == 0, ($urandom % 6) != 0, 4'($urandom), rnd_data(), 0);
    end
    for (int i = 0; i < 6; i++) step(0, 0, '0, '0, 0);

`ifdef FOO_PIPE_ARB_STATS_EN
    for (int i = 0; i < NR; i++) begin
      check("grant_cnt", grant_cnt[i*16 +: 16], (m_gcnt[i] > 65535) ? 16'hFFFF : 16'(m_gcnt[i]));
    end
    step(1, 0, '0, '0, 0);
    step(0, 1, '0, '0, 0);
    for (int i = 0; i < 70000; i++) step(0, 1, 4'b0010, rnd_data(), 0);
    check("grant_cnt_sat", grant_cnt[1*16 +: 16], 16'hFFFF);
    check("grant_cnt_other", grant_cnt[0 +: 16], 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
